// File: rtl/reg_commit_seq_pkg.sv
// rtl/reg_commit_seq_pkg.sv - shared constants, head-type and FSM encodings for reg_commit_seq
package reg_commit_seq_pkg;

    // ROB index width (ROB depth is 2**ROB_BIT).
    localparam int ROB_BIT = 4;

    // Default number of cycles rob_clear_up stays high after a mispredict.
    localparam int DEF_FLUSH_CYCLES = 2;

    typedef enum logic [1:0] {
        TYPE_ALU    = 2'd0,
        TYPE_STORE  = 2'd1,
        TYPE_BRANCH = 2'd2
    } head_type_e;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_STORE_WAIT = 2'd1,
        ST_FLUSH      = 2'd2
    } state_e;

endpackage

// File: rtl/reg_commit_seq_if.sv
// rtl/reg_commit_seq_if.sv - ROB head / register-file commit / store handshake bundle
//
// master : the commit sequencer (consumes head and st_done, drives commit/flush/redirect)
// slave  : the ROB, LSB and register-file side
interface reg_commit_seq_if #(
    parameter int ROB_BIT = reg_commit_seq_pkg::ROB_BIT
);
    // ROB head
    logic               head_valid;
    logic               head_ready;
    logic [1:0]         head_type;
    logic [4:0]         head_rd;
    logic [31:0]        head_value;
    logic [ROB_BIT-1:0] head_entry;
    logic               head_mispredict;
    logic [31:0]        head_target;

    // Register-file commit port
    logic               rob_pop;
    logic               rob_commit;
    logic [4:0]         commit_reg_id;
    logic [31:0]        commit_reg_data;
    logic [ROB_BIT-1:0] commit_rob_entry;

    // Store handshake with the load-store buffer
    logic               st_req;
    logic               st_done;

    // Flush / redirect / statistics
    logic               rob_clear_up;
    logic               redirect;
    logic [31:0]        redirect_pc;
    logic [31:0]        commit_cnt;

    modport master (
        input  head_valid, head_ready, head_type, head_rd, head_value,
               head_entry, head_mispredict, head_target, st_done,
        output rob_pop, rob_commit, commit_reg_id, commit_reg_data,
               commit_rob_entry, st_req, rob_clear_up, redirect,
               redirect_pc, commit_cnt
    );

    modport slave (
        output head_valid, head_ready, head_type, head_rd, head_value,
               head_entry, head_mispredict, head_target, st_done,
        input  rob_pop, rob_commit, commit_reg_id, commit_reg_data,
               commit_rob_entry, st_req, rob_clear_up, redirect,
               redirect_pc, commit_cnt
    );

endinterface

// File: rtl/reg_commit_seq.sv
// rtl/reg_commit_seq.sv - ROB head retirement sequencer into the architectural register file
//
// Ports:
//   clk_in  - system clock
//   rst_in  - synchronous active-high reset
//   rdy_in  - global ready; low freezes all state and gates the strobes
//   bus     - reg_commit_seq_if.master: ROB head in, commit port / store
//             handshake / flush / redirect / retire counter out
// Optional build macro COMMIT_TRACE_EN: prints every commit and stops the
// simulation on store-handshake protocol violations.
module reg_commit_seq
    import reg_commit_seq_pkg::*;
#(
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    reg_commit_seq_if.master  bus
);

    localparam int CNT_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [31:0]        commit_cnt_q, commit_cnt_d;
    logic               st_req_q, st_req_d;
    logic               clear_q, clear_d;
    logic               redirect_q, redirect_d;
    logic [31:0]        redirect_pc_q, redirect_pc_d;
    logic               fire;
    logic               pop;

    always_comb begin
        fire          = rdy_in & bus.head_valid & bus.head_ready;
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        st_req_d      = st_req_q;
        clear_d       = clear_q;
        redirect_d    = 1'b0;          // redirect is a one-cycle pulse
        redirect_pc_d = redirect_pc_q;
        pop           = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (fire) begin
                    if (bus.head_type == TYPE_STORE) begin
                        st_req_d = 1'b1;
                        state_d  = ST_STORE_WAIT;
                    end else begin
                        // Branch commits before the clear so its rd write survives.
                        pop = 1'b1;
                        if (bus.head_type == TYPE_BRANCH && bus.head_mispredict) begin
                            redirect_d    = 1'b1;
                            redirect_pc_d = bus.head_target;
                            clear_d       = 1'b1;
                            flush_cnt_d   = CNT_W'(FLUSH_CYCLES);
                            state_d       = ST_FLUSH;
                        end
                    end
                end
            end
            ST_STORE_WAIT: begin
                if (rdy_in && bus.st_done) begin
                    pop      = 1'b1;
                    st_req_d = 1'b0;
                    state_d  = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (rdy_in) begin
                    flush_cnt_d = flush_cnt_q - CNT_W'(1);
                    if (flush_cnt_q == CNT_W'(1)) begin
                        clear_d = 1'b0;
                        state_d = ST_RUN;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase

        commit_cnt_d = commit_cnt_q + {31'd0, pop};
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= ST_RUN;
            flush_cnt_q   <= '0;
            commit_cnt_q  <= '0;
            st_req_q      <= 1'b0;
            clear_q       <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else if (rdy_in) begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            commit_cnt_q  <= commit_cnt_d;
            st_req_q      <= st_req_d;
            clear_q       <= clear_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign bus.rob_pop          = pop;
    assign bus.rob_commit       = pop;
    // A store never writes a register; the store retire happens outside RUN.
    assign bus.commit_reg_id    = (state_q == ST_RUN && bus.head_type != TYPE_STORE)
                                  ? bus.head_rd : 5'd0;
    assign bus.commit_reg_data  = bus.head_value;
    assign bus.commit_rob_entry = bus.head_entry;
    assign bus.st_req           = st_req_q;
    assign bus.rob_clear_up     = clear_q;
    assign bus.redirect         = redirect_q & rdy_in;
    assign bus.redirect_pc      = redirect_pc_q;
    assign bus.commit_cnt       = commit_cnt_q;

`ifdef COMMIT_TRACE_EN
    logic [31:0] trace_cycle_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            trace_cycle_q <= '0;
        end else begin
            trace_cycle_q <= trace_cycle_q + 32'd1;
            if (pop) begin
                $display("commit cycle=%0d entry=%0d rd=%0d data=%08h",
                         trace_cycle_q, bus.head_entry, bus.commit_reg_id, bus.head_value);
            end
            if (pop && bus.head_type == TYPE_STORE && state_q != ST_STORE_WAIT) begin
                $fatal(1, "store committed outside STORE_WAIT");
            end
            if (bus.st_done && state_q != ST_STORE_WAIT) begin
                $fatal(1, "st_done outside STORE_WAIT");
            end
        end
    end
`endif

endmodule

// File: tb/tb_reg_commit_seq.sv
// tb/tb_reg_commit_seq.sv - self-checking bench for reg_commit_seq against a cycle-level retire model
module tb_reg_commit_seq;
    import reg_commit_seq_pkg::*;

    localparam int RB = ROB_BIT;
    localparam int FC = 2;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;

    always #5 clk_in = ~clk_in;

    reg_commit_seq_if #(.ROB_BIT(RB)) bus ();

    reg_commit_seq #(.FLUSH_CYCLES(FC)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a store outstanding, remaining clear cycles,
    // pending redirect pulse, and the retire count.
    bit          m_wait;
    int          m_flush;
    bit          m_redir;
    logic [31:0] m_rpc;
    logic [31:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wait  = 1'b0;
        m_flush = 0;
        m_redir = 1'b0;
        m_rpc   = '0;
        m_cnt   = '0;
    endtask

    task automatic set_head(input bit v, input bit r, input logic [1:0] t, input logic [4:0] rd,
                            input logic [31:0] val, input logic [RB-1:0] ent,
                            input bit mis, input logic [31:0] tgt);
        bus.head_valid      = v;
        bus.head_ready      = r;
        bus.head_type       = t;
        bus.head_rd         = rd;
        bus.head_value      = val;
        bus.head_entry      = ent;
        bus.head_mispredict = mis;
        bus.head_target     = tgt;
    endtask

    // One clock: check all outputs mid-cycle, then advance the model at the edge.
    task automatic cycle();
        bit          fire;
        bit          pop;
        logic [4:0]  eid;
        @(negedge clk_in);
        fire = rdy_in & bus.head_valid & bus.head_ready;
        pop  = 1'b0;
        eid  = 5'd0;
        if (m_wait) begin
            if (rdy_in && bus.st_done) pop = 1'b1;
        end else if (m_flush == 0 && fire && bus.head_type != 2'd1) begin
            pop = 1'b1;
            eid = bus.head_rd;
        end
        check("rob_pop", bus.rob_pop, pop);
        check("rob_commit", bus.rob_commit, pop);
        if (pop) check("commit_reg_id", bus.commit_reg_id, eid);
        check("commit_reg_data", bus.commit_reg_data, bus.head_value);
        check("commit_rob_entry", bus.commit_rob_entry, bus.head_entry);
        check("redirect", bus.redirect, m_redir & rdy_in);
        check("redirect_pc", bus.redirect_pc, m_rpc);
        check("st_req", bus.st_req, m_wait);
        check("rob_clear_up", bus.rob_clear_up, m_flush > 0);
        check("commit_cnt", bus.commit_cnt, m_cnt);
        @(posedge clk_in);
        if (rst_in) begin
            model_reset();
        end else if (rdy_in) begin
            m_redir = 1'b0;
            if (m_wait) begin
                if (bus.st_done) m_wait = 1'b0;
            end else if (m_flush > 0) begin
                m_flush--;
            end else if (fire) begin
                if (bus.head_type == 2'd1) begin
                    m_wait = 1'b1;
                end else if (bus.head_type == 2'd2 && bus.head_mispredict) begin
                    m_redir = 1'b1;
                    m_rpc   = bus.head_target;
                    m_flush = FC;
                end
            end
            m_cnt = m_cnt + {31'd0, pop};
        end
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        set_head(0, 0, 2'd0, 5'd0, 32'd0, '0, 0, 32'd0);
        bus.st_done = 1'b0;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        model_reset();
    endtask

    initial begin
        rst_in = 1'b1;
        rdy_in = 1'b1;
        bus.st_done = 1'b0;
        set_head(0, 0, 2'd0, 5'd0, 32'd0, '0, 0, 32'd0);
        model_reset();
        @(posedge clk_in);
        #1;
        do_reset();
        cycle();

        // Three ALU heads back to back.
        for (int i = 0; i < 3; i++) begin
            set_head(1, 1, 2'd0, 5'(5 + i), 32'h11 * (i + 1), RB'(i), 0, 32'd0);
            cycle();
        end
        check("cnt_after_alu3", bus.commit_cnt, 32'd3);

        // Store: request, wait, done on the fourth cycle.
        set_head(1, 1, 2'd1, 5'd3, 32'hdead, RB'(3), 0, 32'd0);
        cycle();
        check("st_req_after_store", bus.st_req, 1'b1);
        for (int i = 0; i < 3; i++) cycle();
        bus.st_done = 1'b1;
        cycle();
        bus.st_done = 1'b0;
        set_head(0, 0, 2'd0, 5'd0, 32'd0, '0, 0, 32'd0);
        cycle();
        check("cnt_after_store", bus.commit_cnt, 32'd4);

        // Mispredicted JALR, then a ready ALU head held through the flush.
        set_head(1, 1, 2'd2, 5'd1, 32'h1004, RB'(5), 1, 32'h2000);
        cycle();
        check("redirect_pc_jalr", bus.redirect_pc, 32'h2000);
        set_head(1, 1, 2'd0, 5'd9, 32'h99, RB'(6), 0, 32'd0);
        for (int i = 0; i < 3; i++) cycle();
        check("cnt_after_flush", bus.commit_cnt, 32'd6);

        // rdy_in low freezes an ALU commit.
        set_head(1, 1, 2'd0, 5'd4, 32'h44, RB'(7), 0, 32'd0);
        rdy_in = 1'b0;
        cycle();
        cycle();
        rdy_in = 1'b1;
        cycle();

        // rdy_in low in STORE_WAIT ignores st_done.
        set_head(1, 1, 2'd1, 5'd0, 32'h55, RB'(8), 0, 32'd0);
        cycle();
        rdy_in = 1'b0;
        bus.st_done = 1'b1;
        cycle();
        rdy_in = 1'b1;
        bus.st_done = 1'b0;
        cycle();
        cycle();
        bus.st_done = 1'b1;
        cycle();
        bus.st_done = 1'b0;

        // Reset in the middle of a flush.
        set_head(1, 1, 2'd2, 5'd2, 32'h77, RB'(9), 1, 32'h3000);
        cycle();
        set_head(0, 0, 2'd0, 5'd0, 32'd0, '0, 0, 32'd0);
        cycle();
        do_reset();
        check("clear_after_reset", bus.rob_clear_up, 1'b0);
        check("cnt_after_reset", bus.commit_cnt, 32'd0);
        cycle();

        // Retire counter wrap.
        force dut.commit_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.commit_cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        set_head(1, 1, 2'd0, 5'd8, 32'h88, RB'(1), 0, 32'd0);
        cycle();
        check("cnt_wrap", bus.commit_cnt, 32'd0);

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            rst_in = ($urandom_range(0, 99) == 0);
            rdy_in = ($urandom_range(0, 9) != 0);
            set_head($urandom_range(0, 4) != 0, $urandom_range(0, 9) < 7,
                     2'($urandom_range(0, 2)), 5'($urandom), $urandom, RB'($urandom),
                     $urandom_range(0, 1) == 1, $urandom);
            bus.st_done = m_wait && ($urandom_range(0, 3) == 0);
            cycle();
        end
        rst_in = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
